// File: rtl/seq_restoring_divider_pkg.sv
// Shared definitions for the sequential restoring divider.
//   state_t          : controller state encoding (IDLE, RUN, DONE)
//   DEFAULT_WIDTH    : default operand width
//   DEFAULT_CNT_W    : iteration counter width for the default operand width
//   count_width()    : iteration counter width for any legal operand width
package seq_restoring_divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_CNT_W = $clog2(DEFAULT_WIDTH);

    // The counter runs 0..width-1; a width of 2 still needs one bit.
    function automatic int count_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/seq_restoring_divider_trial_subtractor.sv
// Trial subtractor for one restoring-division step.
//   a, b   : N-bit operands (callers zero-extend by one bit)
//   diff   : a - b, formed as a + ~b with a carry-in of 1
//   borrow : high when a < b, i.e. the inverted carry-out
module seq_restoring_divider_trial_subtractor #(
    parameter int N = 9
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         borrow
);

    logic [N:0] sum;

    assign sum    = {1'b0, a} + {1'b0, ~b} + {{N{1'b0}}, 1'b1};
    assign diff   = sum[N-1:0];
    assign borrow = ~sum[N];

endmodule

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
//   clk, reset       : rising-edge clock, asynchronous active-high reset
//   start            : request, accepted only in IDLE or DONE
//   dividend/divisor : operands, latched when start is accepted
//   busy             : high while iterating (RUN)
//   done             : one-cycle pulse when results become valid
//   quotient/remainder/div_by_zero : results, held until the next DONE
// Handshake: a request is taken on any rising edge where start=1 and the
// controller is in IDLE or DONE; start is ignored while busy=1. done is
// asserted for exactly the one cycle spent in DONE.
module seq_restoring_divider
    import seq_restoring_divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int            CW   = count_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state, state_next;
    logic [WIDTH-1:0] rem, dq, dvsr;
    logic [CW-1:0]    count;

    logic [WIDTH-1:0] shifted, rem_next, dq_next;
    logic [WIDTH:0]   trial;
    logic             borrow, restore;
    logic             accept, finish;

    // The partial remainder is below 2**(WIDTH-1) on every iteration except
    // the last, so dropping its MSB while shifting loses nothing.
    assign shifted = {rem[WIDTH-2:0], dq[WIDTH-1]};

    seq_restoring_divider_trial_subtractor #(.N(WIDTH + 1)) u_trial (
        .a      ({1'b0, shifted}),
        .b      ({1'b0, dvsr}),
        .diff   (trial),
        .borrow (borrow)
    );

    // With zero-extended operands the borrow and the trial MSB agree.
    assign restore  = borrow | trial[WIDTH];
    assign rem_next = restore ? shifted : trial[WIDTH-1:0];
    assign dq_next  = {dq[WIDTH-2:0], ~restore};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        finish     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = (divisor == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (count == LAST) begin
                    finish     = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    accept     = 1'b1;
                    state_next = (divisor == '0) ? DONE : RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Results are only written when DONE is entered, so they stay valid
    // through an accepted start until the new division completes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem         <= '0;
            dq          <= '0;
            dvsr        <= '0;
            count       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            if (divisor == '0) begin
                quotient    <= '1;
                remainder   <= dividend;
                div_by_zero <= 1'b1;
            end else begin
                dvsr  <= divisor;
                rem   <= '0;
                dq    <= dividend;
                count <= '0;
            end
        end else if (state == RUN) begin
            rem   <= rem_next;
            dq    <= dq_next;
            count <= count + CW'(1);
            if (finish) begin
                quotient    <= dq_next;
                remainder   <= rem_next;
                div_by_zero <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider (WIDTH=8): directed cases,
// mid-run start and reset, then a randomized sweep against a / and % model.
module tb_seq_restoring_divider;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] dividend, divisor;
    logic         busy, done, div_by_zero;
    logic [W-1:0] quotient, remainder;

    int checks = 0;
    int errors = 0;

    // Scoreboard entries: {div_by_zero, quotient, remainder} and {a, b}.
    logic [2*W:0]   exp_q[$];
    logic [2*W-1:0] op_q[$];
    logic [2*W:0]   last_exp;

    always #5 clk = ~clk;

    seq_restoring_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [2*W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        int ai, bi;
        ai = int'(a);
        bi = int'(b);
        if (bi == 0) return {1'b1, {W{1'b1}}, a};
        return {1'b0, W'(ai / bi), W'(ai % bi)};
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Drives a one-cycle start; returns 1 ns after the sampling edge.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        cycle();
        start = 1'b0;
        exp_q.push_back(model(a, b));
        op_q.push_back({a, b});
    endtask

    // n0 = edges already seen since (and including) the start edge.
    task automatic wait_done(input string tag, input int n0, input int exp_lat, input int exp_busy);
        int n, bc;
        logic [2*W:0]   e;
        logic [2*W-1:0] op;
        n  = n0;
        bc = 0;
        while (!done && n < 40) begin
            if (busy) bc++;
            cycle();
            n++;
        end
        check({tag, "_latency"}, n, exp_lat);
        check({tag, "_busy_cycles"}, bc, exp_busy);
        check({tag, "_sb_depth"}, exp_q.size(), 1);
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            op = op_q.pop_front();
            last_exp = e;
            check({tag, "_quotient"}, quotient, e[2*W-1:W]);
            check({tag, "_remainder"}, remainder, e[W-1:0]);
            check({tag, "_div_by_zero"}, div_by_zero, e[2*W]);
            if (!e[2*W]) begin
                check({tag, "_invariant"}, quotient * op[W-1:0] + remainder, op[2*W-1:W]);
                check({tag, "_rem_lt_div"}, 32'(remainder < op[W-1:0]), 1);
            end
        end
    endtask

    task automatic idle_hold(input string tag);
        cycle();
        check({tag, "_done_low"}, done, 0);
        check({tag, "_busy_low"}, busy, 0);
        check({tag, "_q_held"}, quotient, last_exp[2*W-1:W]);
        check({tag, "_r_held"}, remainder, last_exp[W-1:0]);
        check({tag, "_dz_held"}, div_by_zero, last_exp[2*W]);
    endtask

    initial begin
        logic [W-1:0] a_tab [3];
        logic [W-1:0] b_tab [3];
        logic [W-1:0] ra, rb;
        int seen, k;

        reset    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        last_exp = '0;
        repeat (2) cycle();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_quotient", quotient, 0);
        check("rst_remainder", remainder, 0);
        check("rst_dz", div_by_zero, 0);
        reset = 1'b0;
        cycle();

        // Basic divide.
        start_op(8'd100, 8'd7);
        wait_done("t1", 1, 9, 8);
        idle_hold("t1_hold");

        // Boundary operands.
        a_tab = '{8'd255, 8'd5, 8'd255};
        b_tab = '{8'd1,   8'd9, 8'd255};
        for (int i = 0; i < 3; i++) begin
            start_op(a_tab[i], b_tab[i]);
            wait_done("t2", 1, 9, 8);
            idle_hold("t2_hold");
        end

        // Divide by zero.
        start_op(8'd77, 8'd0);
        wait_done("t3", 1, 1, 0);
        idle_hold("t3_hold");

        // start during RUN is ignored, operand changes have no effect.
        start_op(8'd200, 8'd3);
        repeat (3) cycle();
        start    = 1'b1;
        dividend = 8'd9;
        divisor  = 8'd2;
        cycle();
        start = 1'b0;
        wait_done("t4a", 5, 9, 4);
        // Back-to-back start taken in the DONE cycle.
        start_op(8'd9, 8'd2);
        wait_done("t4b", 1, 9, 8);
        idle_hold("t4_hold");

        // Asynchronous reset in the middle of RUN.
        start_op(8'd100, 8'd7);
        repeat (2) cycle();
        #3;
        reset = 1'b1;
        #1;
        check("t5_rst_quotient", quotient, 0);
        check("t5_rst_remainder", remainder, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_done", done, 0);
        check("t5_rst_dz", div_by_zero, 0);
        exp_q.delete();
        op_q.delete();
        @(negedge clk);
        reset = 1'b0;
        seen  = 0;
        repeat (12) begin
            cycle();
            if (done) seen++;
        end
        check("t5_no_done", seen, 0);
        start_op(8'd50, 8'd6);
        wait_done("t5b", 1, 9, 8);
        idle_hold("t5_hold");

        // Random sweep; zero idle cycles means a back-to-back start in DONE.
        for (int i = 0; i < 1000; i++) begin
            ra = W'($urandom_range(0, 255));
            rb = ($urandom_range(0, 15) == 0) ? 8'd0 : W'($urandom_range(1, 255));
            start_op(ra, rb);
            if (rb == 8'd0) wait_done("rnd", 1, 1, 0);
            else            wait_done("rnd", 1, 9, 8);
            k = $urandom_range(0, 2);
            for (int j = 0; j < k; j++) idle_hold("rnd_hold");
        end
        idle_hold("final_hold");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_restoring_divider.md
Name: seq_restoring_divider

Overview:
- Multi-cycle unsigned integer divider. It is the inverse of the team's adder datapath: each iteration is a trial subtraction built on the same add-with-inverted-operand scheme, plus a carry-in of 1.
- Computes quotient and remainder of two WIDTH-bit operands, one quotient bit per clock.
- Uses a start/busy/done handshake.
- Sits beside the adder blocks in the lab ALU as the divide unit.

Parameters:
- WIDTH, 8, operand/result width in bits (legal range 2..32)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous active-high reset
- start  input  1  request; sampled only in IDLE or DONE
- dividend  input  WIDTH  numerator; latched on accepted start
- divisor  input  WIDTH  denominator; latched on accepted start
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse when results become valid
- quotient  output  WIDTH  result; held until next accepted start
- remainder  output  WIDTH  result; held until next accepted start
- div_by_zero  output  1  set with done when divisor was 0; held with results

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (reset).
- Reset values:
  - state=IDLE, busy=0, done=0
  - quotient=0, remainder=0, div_by_zero=0
  - internal count and registers cleared
- Reset asserted mid-RUN aborts immediately; no done is produced.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 and divisor!=0: latch operands, rem=0, dq=dividend, count=0, go to RUN.
  - start=1 and divisor==0: go to DONE. quotient={WIDTH{1}}, remainder=dividend, div_by_zero=1.
  - start=0: stay in IDLE.
- RUN, one iteration per edge:
  - shifted = {rem[WIDTH-2:0], dq[WIDTH-1]}; dq shifts left.
  - trial = {1'b0,shifted} - {1'b0,divisor_reg}, computed as a+~b+1 in WIDTH+1 bits.
  - No borrow (trial MSB=0): rem=trial[WIDTH-1:0], new dq LSB=1.
  - Borrow: rem=shifted, new dq LSB=0.
  - count increments each iteration.
  - On the iteration with count==WIDTH-1: go to DONE, load quotient=dq_next and remainder=rem_next, div_by_zero=0.
- Handshake and latency:
  - start is ignored in RUN; operand changes during RUN have no effect.
  - busy=1 exactly during RUN.
  - Normal divide: done is high for the one cycle following the (WIDTH+1)th rising edge, counting the edge that sampled start.
  - Divide by zero: done follows the very next edge.
- DONE: done=1 for exactly one cycle.
  - start=1 in DONE is accepted exactly as in IDLE (back-to-back operation, no idle gap).
  - Otherwise go to IDLE.
- Results stay stable from DONE until the next accepted start. On an accepted start they are not cleared; they update only when the new DONE is entered.
- Invariant: dividend == quotient*divisor + remainder, with remainder < divisor (divisor != 0).

Decomposition:
- Shared package:
  - state encoding constants: IDLE=2'd0, RUN=2'd1, DONE=2'd2
  - a localparam for the count width = clog2(WIDTH)
- One sub-module, trial_subtractor (WIDTH+1 bits):
  - inputs a, b
  - outputs diff and borrow
  - implemented as a + ~b with carry-in 1; borrow = ~carry_out.
- FSM, shift registers and result registers stay in the top module.

Test Plan:
1. WIDTH=8, dividend=100, divisor=7, start for 1 cycle -> busy high 8 cycles; done pulse 9 edges after start; quotient=14, remainder=2, div_by_zero=0.
2. Boundary operands:
   - 255/1 -> quotient=255, remainder=0.
   - 5/9 -> quotient=0, remainder=5.
   - 255/255 -> quotient=1, remainder=0.
3. dividend=77, divisor=0 -> done one edge after start; quotient=8'hFF, remainder=77, div_by_zero=1; busy never high.
4. Start 200/3; pulse start with 9/2 at RUN cycle 4 -> ignored; result quotient=66, remainder=2. Then start 9/2 in the DONE cycle -> accepted immediately; quotient=4, remainder=1; done 9 edges later.
5. Start 100/7; assert reset asynchronously (between clock edges) at RUN cycle 3 -> outputs zero immediately with no clock edge; no done pulse. Next start 50/6 -> quotient=8, remainder=2.
6. Random sweep of 1000 operand pairs -> dividend == quotient*divisor + remainder and remainder < divisor on every done; results hold until the next start.
